islem_denetleyici: RTL

- Sequencing controller for the calculator's arithmetic units: toplama, cikarma, carpma, bolme.
- Accepts one operation request at a time over a valid/ready handshake and registers the operands onto a shared operand bus.
- Selects exactly one unit, waits for that unit's hazir/gecerli, then captures the result and holds it on an output valid/ready handshake.
- Sits between the keypad/input front end and the arithmetic units; the unit result bus is muxed outside the block using birim_sec.

---
 rtl/hesap_pkg.sv | 36 +++
 rtl/islem_sayaci.sv | 32 +++
 rtl/islem_denetleyici.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/hesap_pkg.sv
// Shared definitions for the calculator's arithmetic sequencing logic.
package hesap_pkg;

  localparam int unsigned VARSAYILAN_GENISLIK    = 32;
  localparam int unsigned VARSAYILAN_MIN_BEKLE   = 1;
  localparam int unsigned VARSAYILAN_ZAMAN_ASIMI = 16;
  localparam int unsigned BIRIM_SAYISI           = 4;
  localparam int unsigned KOD_GENISLIK           = 2;

  localparam logic [KOD_GENISLIK-1:0] TOPLAMA = 2'b00;
  localparam logic [KOD_GENISLIK-1:0] CIKARMA = 2'b01;
  localparam logic [KOD_GENISLIK-1:0] CARPMA  = 2'b10;
  localparam logic [KOD_GENISLIK-1:0] BOLME   = 2'b11;

  typedef enum logic [1:0] {
    BOS   = 2'd0,
    YUKLE = 2'd1,
    BEKLE = 2'd2,
    CIKIS = 2'd3
  } durum_e;

  // One-hot unit select for an operation code.
  function automatic logic [BIRIM_SAYISI-1:0] birim_onehot(input logic [KOD_GENISLIK-1:0] kod);
    logic [BIRIM_SAYISI-1:0] secim;
    secim = '0;
    case (kod)
      TOPLAMA: secim = 4'b0001;
      CIKARMA: secim = 4'b0010;
      CARPMA:  secim = 4'b0100;
      BOLME:   secim = 4'b1000;
      default: secim = '0;
    endcase
    return secim;
  endfunction

endpackage

// File: rtl/islem_sayaci.sv
// Wait-state counter: counts BEKLE cycles and flags the minimum-wait and timeout points.
module islem_sayaci
  import hesap_pkg::*;
#(
  parameter int unsigned MIN_BEKLE   = VARSAYILAN_MIN_BEKLE,
  parameter int unsigned ZAMAN_ASIMI = VARSAYILAN_ZAMAN_ASIMI
) (
  input  logic clk,
  input  logic rst,
  input  logic temizle,
  input  logic sayim_etkin,
  output logic ge_min_c,
  output logic zaman_asimi_c
);

  localparam int unsigned SAYAC_GENISLIK = $clog2(ZAMAN_ASIMI + 1);

  logic [SAYAC_GENISLIK-1:0] sayac;

  // Counter never wraps: the controller leaves BEKLE when it reaches ZAMAN_ASIMI.
  always_ff @(posedge clk) begin
    if (rst || temizle) begin
      sayac <= '0;
    end else if (sayim_etkin) begin
      sayac <= sayac + SAYAC_GENISLIK'(1);
    end
  end

  assign ge_min_c      = (sayac >= SAYAC_GENISLIK'(MIN_BEKLE));
  assign zaman_asimi_c = (sayac == SAYAC_GENISLIK'(ZAMAN_ASIMI));

endmodule

// File: rtl/islem_denetleyici.sv
// Sequences one arithmetic operation at a time through the selected unit.
module islem_denetleyici
  import hesap_pkg::*;
#(
  parameter int unsigned GENISLIK    = VARSAYILAN_GENISLIK,
  parameter int unsigned MIN_BEKLE   = VARSAYILAN_MIN_BEKLE,
  parameter int unsigned ZAMAN_ASIMI = VARSAYILAN_ZAMAN_ASIMI
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      istek_gecerli,
  output logic                      istek_hazir,
  input  logic [KOD_GENISLIK-1:0]   islem_kodu,
  input  logic [GENISLIK-1:0]       sayi1,
  input  logic [GENISLIK-1:0]       sayi2,
  output logic [GENISLIK-1:0]       birim_sayi1,
  output logic [GENISLIK-1:0]       birim_sayi2,
  output logic [BIRIM_SAYISI-1:0]   birim_sec,
  output logic                      birim_basla,
  input  logic [BIRIM_SAYISI-1:0]   birim_hazir,
  input  logic [BIRIM_SAYISI-1:0]   birim_gecerli,
  input  logic [BIRIM_SAYISI-1:0]   birim_tasma,
  input  logic [2*GENISLIK-1:0]     birim_sonuc,
  output logic [2*GENISLIK-1:0]     sonuc,
  output logic                      tasma,
  output logic                      hata,
  output logic                      cikis_gecerli,
  input  logic                      cikis_hazir
);

  durum_e                    durum_q, durum_d;
  logic [KOD_GENISLIK-1:0]   kod_q, kod_d;
  logic [GENISLIK-1:0]       birim_sayi1_d, birim_sayi2_d;
  logic [BIRIM_SAYISI-1:0]   birim_sec_d;
  logic                      birim_basla_d;
  logic [2*GENISLIK-1:0]     sonuc_d;
  logic                      tasma_d, hata_d, cikis_gecerli_d;
  logic                      sayac_temizle, sayac_say;
  logic                      ge_min_c, zaman_asimi_c;
  logic                      yakala_c;

  islem_sayaci #(
    .MIN_BEKLE   (MIN_BEKLE),
    .ZAMAN_ASIMI (ZAMAN_ASIMI)
  ) u_sayac (
    .clk           (clk),
    .rst           (rst),
    .temizle       (sayac_temizle),
    .sayim_etkin   (sayac_say),
    .ge_min_c      (ge_min_c),
    .zaman_asimi_c (zaman_asimi_c)
  );

  assign istek_hazir = (durum_q == BOS);

  // Only the selected unit's flags count, and only once the minimum wait has passed.
  assign yakala_c = ge_min_c & birim_hazir[kod_q] & birim_gecerli[kod_q];

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      durum_q       <= BOS;
      kod_q         <= '0;
      birim_sayi1   <= '0;
      birim_sayi2   <= '0;
      birim_sec     <= '0;
      birim_basla   <= 1'b0;
      sonuc         <= '0;
      tasma         <= 1'b0;
      hata          <= 1'b0;
      cikis_gecerli <= 1'b0;
    end else begin
      durum_q       <= durum_d;
      kod_q         <= kod_d;
      birim_sayi1   <= birim_sayi1_d;
      birim_sayi2   <= birim_sayi2_d;
      birim_sec     <= birim_sec_d;
      birim_basla   <= birim_basla_d;
      sonuc         <= sonuc_d;
      tasma         <= tasma_d;
      hata          <= hata_d;
      cikis_gecerli <= cikis_gecerli_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    durum_d         = durum_q;
    kod_d           = kod_q;
    birim_sayi1_d   = birim_sayi1;
    birim_sayi2_d   = birim_sayi2;
    birim_sec_d     = birim_sec;
    birim_basla_d   = 1'b0;
    sonuc_d         = sonuc;
    tasma_d         = tasma;
    hata_d          = hata;
    cikis_gecerli_d = cikis_gecerli;
    sayac_temizle   = 1'b0;
    sayac_say       = 1'b0;

    case (durum_q)
      BOS: begin
        if (istek_gecerli) begin
          birim_sayi1_d = sayi1;
          birim_sayi2_d = sayi2;
          kod_d         = islem_kodu;
          if ((islem_kodu == BOLME) && (sayi2 == '0)) begin
            // Division by zero never reaches a unit.
            durum_d         = CIKIS;
            birim_sec_d     = '0;
            sonuc_d         = '0;
            tasma_d         = 1'b0;
            hata_d          = 1'b1;
            cikis_gecerli_d = 1'b1;
          end else begin
            durum_d       = YUKLE;
            birim_sec_d   = birim_onehot(islem_kodu);
            birim_basla_d = 1'b1;
          end
        end
      end

      YUKLE: begin
        durum_d       = BEKLE;
        sayac_temizle = 1'b1;
      end

      BEKLE: begin
        sayac_say = 1'b1;
        if (yakala_c) begin
          durum_d         = CIKIS;
          birim_sec_d     = '0;
          sonuc_d         = birim_sonuc;
          tasma_d         = birim_tasma[kod_q];
          hata_d          = 1'b0;
          cikis_gecerli_d = 1'b1;
        end else if (zaman_asimi_c) begin
          durum_d         = CIKIS;
          birim_sec_d     = '0;
          sonuc_d         = '0;
          tasma_d         = 1'b0;
          hata_d          = 1'b1;
          cikis_gecerli_d = 1'b1;
        end
      end

      CIKIS: begin
        if (cikis_hazir) begin
          durum_d         = BOS;
          cikis_gecerli_d = 1'b0;
        end
      end

      default: begin
        durum_d = BOS;
      end
    endcase
  end

endmodule
